datapath_seq: RTL and testbench
===============================

// Module: datapath_seq
// PURPOSE
//  Parametrised successor to the lab datapath: register file, A/B operand regs, B-path shifter, ALU, C reg, status.
//  Adds an internal sequencer, so one command issued over a valid/ready handshake runs as a fixed multi-cycle micro-sequence.
//  Sits between the future instruction-decode FSM and the register/ALU resources; replaces per-signal load strobes.
// PARAMETERS
//  DATA_W  16  datapath/register width in bits (>=4)
//  NREGS   8   number of registers; power of 2, >=2; RA_W = $clog2(NREGS)
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       sequencer idle; command accepted on clk edge with cmd_valid&cmd_ready
//  cmd_op     in   3       000 MOVI, 001 ADD, 010 CMP, 011 AND, 100 MVN, 101 MOV; 110/111 illegal
//  cmd_rd     in   RA_W    destination register
//  cmd_rn     in   RA_W    operand A register
//  cmd_rm     in   RA_W    operand B register (shifted)
//  cmd_shift  in   2       00 none, 01 LSL#1, 10 LSR#1, 11 ASR#1 (applied to B)
//  cmd_imm    in   DATA_W  immediate for MOVI
//  done       out  1       one-cycle pulse: command retired
//  result     out  DATA_W  C register (last ALU result / MOVI value)
//  Z, N, V    out  1 each  status flags
//  dbg_rnum   in   RA_W    debug read select
//  dbg_rdata  out  DATA_W  combinational R[dbg_rnum]
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, all registers, A, B, C=0, Z=N=V=0, done=0; cmd_ready=1 once reset is released.
//  - Command fields are latched at accept; inputs ignored while busy (cmd_ready=0).
//  - FSM: IDLE -accept-> RDA (A<=R[rn]) -> RDB (B<=R[rm]) -> EXEC (C<=ALU, flags) -> WB (R[rd]<=C) -> IDLE.
//    MOVI: IDLE -accept-> WB (C<=imm, R[rd]<=imm).
//    Illegal op: IDLE -accept-> WB; no write, C/flags unchanged, done still pulses.
//  - cmd_ready = (state==IDLE). done is registered: set on the edge leaving WB, cleared on the next edge.
//  - Latency (accept edge = E0): ALU ops: done high E4..E5. MOVI/illegal: done high E1..E2.
//    A new command may be accepted while done is high.
//  - ALU with Bs = shift(B):
//    ADD: A+Bs mod 2^DATA_W.
//    CMP: A-Bs; flags only; no register write; C still updated.
//    AND: A&Bs.  MVN: ~Bs.  MOV: Bs.  A is unused for MVN/MOV.
//  - Shifts: LSR fills 0; ASR replicates MSB; LSL drops MSB.
//  - Flags update only in EXEC:
//    Z = (ALU==0).
//    N = ALU[DATA_W-1].
//    V = signed overflow for ADD/CMP, 0 for others.
//    MOVI leaves flags unchanged.
//  - rd==rn==rm is legal: operands read before WB.
//  - dbg_rdata reflects a WB write from the edge after that write.
// CONFIGURATION
//  DP_STATUS_NV_EN defined: N and V are computed as above.
//  Not defined: N and V are tied to 0 and their flops are omitted; Z is unaffected.
// TESTING
//  1. MOVI R0,#7; MOVI R1,#2; ADD R2,R1,R0,LSL#1 -> result=16, dbg R2=16, Z=0, done 4 cycles after ADD accept.
//  2. CMP R0,R0 (R0=7) -> Z=1, result=0, R0..R7 unchanged; illegal op 111 -> done pulses, flags/C unchanged.
//  3. R0=0x7FFF, R1=1, ADD R3,R0,R1 -> 0x8000, Z=0; with DP_STATUS_NV_EN N=1,V=1, without N=V=0.
//  4. R4=0x8004: MOV R5,R4,ASR -> 0xC002; MOV R6,R4,LSR -> 0x4002; MVN R7,R4 -> 0x7FFB.
//  5. Hold cmd_valid during busy -> no extra accept; accept a command in the done cycle -> back-to-back retirement.
//     Drop rst_n mid-EXEC -> all outputs/regs 0, cmd_ready=1.
//  6. DATA_W=8, NREGS=4: 0xFF ADD 0x01 -> result=0x00, Z=1; rd index wraps within 2 bits.

Source files
------------

// File: rtl/datapath_seq_if.sv
// Command channel (valid/ready) and retire/status bundle between the decode FSM and datapath_seq.
interface datapath_seq_if #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
);
  localparam int RA_W = $clog2(NREGS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [RA_W-1:0]   cmd_rd;
  logic [RA_W-1:0]   cmd_rn;
  logic [RA_W-1:0]   cmd_rm;
  logic [1:0]        cmd_shift;
  logic [DATA_W-1:0] cmd_imm;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              Z;
  logic              N;
  logic              V;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm,
    input  cmd_ready, done, result, Z, N, V
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm,
    output cmd_ready, done, result, Z, N, V
  );
endinterface

// File: rtl/datapath_seq.sv
// Register file + A/B/C datapath driven by an internal sequencer; one command runs RDA->RDB->EXEC->WB.
// Optional DP_STATUS_NV_EN: when defined, N and V flags are computed; otherwise they are tied to 0.
module datapath_seq #(
  parameter int  DATA_W = 16,
  parameter int  NREGS  = 8,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  datapath_seq_if.slave     bus,
  input  logic [RA_W-1:0]   dbg_rnum,
  output logic [DATA_W-1:0] dbg_rdata
);
  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_CMP  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_MVN  = 3'd4;
  localparam logic [2:0] OP_MOV  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [RA_W-1:0]   rd_reg, rn_reg, rm_reg;
  logic [1:0]        shift_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] a_reg, b_reg, c_reg;
  logic              z_reg;
  logic              done_reg;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] bs, sum, diff, alu_y, wb_data;
  logic              accept, wb_we;

  assign bus.cmd_ready = (state_reg == S_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // CMP goes through EXEC for the flags but never writes back; illegal ops write nothing.
  assign wb_we   = (state_reg == S_WB) &&
                   (op_reg inside {OP_MOVI, OP_ADD, OP_AND, OP_MVN, OP_MOV});
  assign wb_data = (op_reg == OP_MOVI) ? imm_reg : c_reg;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          reg_q <= '0;
        else if (wb_we && (rd_reg == RA_W'(gi)))
          reg_q <= wb_data;
      end
      assign regs[gi] = reg_q;
    end
  endgenerate

  assign dbg_rdata = regs[dbg_rnum];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept)
                state_next = (bus.cmd_op inside {OP_ADD, OP_CMP, OP_AND, OP_MVN, OP_MOV})
                             ? S_RDA : S_WB;
      S_RDA:  state_next = S_RDB;
      S_RDB:  state_next = S_EXEC;
      S_EXEC: state_next = S_WB;
      S_WB:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bs = b_reg;
    case (shift_reg)
      2'b01:   bs = {b_reg[MSB-1:0], 1'b0};
      2'b10:   bs = {1'b0, b_reg[MSB:1]};
      2'b11:   bs = {b_reg[MSB], b_reg[MSB:1]};
      default: bs = b_reg;
    endcase
  end

  assign sum  = a_reg + bs;
  assign diff = a_reg - bs;

  always_comb begin
    alu_y = '0;
    case (op_reg)
      OP_ADD:  alu_y = sum;
      OP_CMP:  alu_y = diff;
      OP_AND:  alu_y = a_reg & bs;
      OP_MVN:  alu_y = ~bs;
      OP_MOV:  alu_y = bs;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      rd_reg    <= '0;
      rn_reg    <= '0;
      rm_reg    <= '0;
      shift_reg <= '0;
      imm_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      z_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == S_WB);
      if (accept) begin
        op_reg    <= bus.cmd_op;
        rd_reg    <= bus.cmd_rd;
        rn_reg    <= bus.cmd_rn;
        rm_reg    <= bus.cmd_rm;
        shift_reg <= bus.cmd_shift;
        imm_reg   <= bus.cmd_imm;
      end
      if (state_reg == S_RDA)
        a_reg <= regs[rn_reg];
      if (state_reg == S_RDB)
        b_reg <= regs[rm_reg];
      if (state_reg == S_EXEC) begin
        c_reg <= alu_y;
        z_reg <= (alu_y == '0);
      end
      if ((state_reg == S_WB) && (op_reg == OP_MOVI))
        c_reg <= imm_reg;
    end
  end

  assign bus.done   = done_reg;
  assign bus.result = c_reg;
  assign bus.Z      = z_reg;

`ifdef DP_STATUS_NV_EN
  logic n_reg, v_reg, alu_v;

  // Two's-complement overflow: operands agree in sign (after negating B for CMP) but result differs.
  always_comb begin
    alu_v = 1'b0;
    if (op_reg == OP_ADD)
      alu_v = (a_reg[MSB] == bs[MSB]) && (sum[MSB] != a_reg[MSB]);
    else if (op_reg == OP_CMP)
      alu_v = (a_reg[MSB] != bs[MSB]) && (diff[MSB] != a_reg[MSB]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg <= 1'b0;
      v_reg <= 1'b0;
    end else if (state_reg == S_EXEC) begin
      n_reg <= alu_y[MSB];
      v_reg <= alu_v;
    end
  end

  assign bus.N = n_reg;
  assign bus.V = v_reg;
`else
  assign bus.N = 1'b0;
  assign bus.V = 1'b0;
`endif
endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a per-cycle reference model plus literal checks from the worked examples.
module tb_datapath_seq;
`ifdef DP_STATUS_NV_EN
  localparam bit NV_EN = 1'b1;
`else
  localparam bit NV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  dbg_rnum;
  logic [15:0] dbg_rdata;
  logic [1:0]  dbg8_rnum;
  logic [7:0]  dbg8_rdata;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int last_e0 = 0;

  datapath_seq_if #(.DATA_W(16), .NREGS(8)) bus ();
  datapath_seq_if #(.DATA_W(8),  .NREGS(4)) bus8 ();

  datapath_seq #(.DATA_W(16), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_rnum(dbg_rnum), .dbg_rdata(dbg_rdata));
  datapath_seq #(.DATA_W(8), .NREGS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_rnum(dbg8_rnum), .dbg_rdata(dbg8_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          e0;
    int          c_cyc;
    int          done_cyc;
    bit          upd_c;
    bit          upd_f;
    bit          we;
    logic [2:0]  rd;
    logic [15:0] y;
    logic        z, n, v;
  } item_t;

  function automatic item_t model(input logic [2:0] op, input logic [2:0] rd,
                                  input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] sh, input logic [15:0] imm, input int e0);
    item_t it;
    logic [15:0] bsv;
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (sh)
      2'b01:   bsv = 16'(int'(b) * 2);
      2'b10:   bsv = 16'(int'(b) / 2);
      2'b11:   bsv = 16'(((sb < 0) && (sb % 2 != 0)) ? (sb / 2 - 1) : (sb / 2));
      default: bsv = b;
    endcase
    sb = int'($signed(bsv));
    it = '{e0: e0, c_cyc: e0 + 3, done_cyc: e0 + 4, upd_c: 1, upd_f: 1, we: 1,
           rd: rd, y: '0, z: 0, n: 0, v: 0};
    r = 0;
    case (op)
      3'd1: begin r = sa + sb; it.y = 16'(r); end
      3'd2: begin r = sa - sb; it.y = 16'(r); it.we = 0; end
      3'd3: it.y = a & bsv;
      3'd4: it.y = ~bsv;
      3'd5: it.y = bsv;
      3'd0: begin
        it.y = imm; it.c_cyc = e0 + 1; it.done_cyc = e0 + 1; it.upd_f = 0;
      end
      default: begin
        it.c_cyc = e0 + 1; it.done_cyc = e0 + 1; it.upd_c = 0; it.upd_f = 0; it.we = 0;
      end
    endcase
    it.z = (it.y == 16'd0);
    it.n = it.y[15] & NV_EN;
    it.v = ((op == 3'd1) || (op == 3'd2)) && (r > 32767 || r < -32768) && NV_EN;
    return it;
  endfunction

  item_t       q[$];
  logic [15:0] m_regs [8];
  logic [15:0] m_c;
  logic        m_z, m_n, m_v;
  logic        exp_ready, exp_done;
  logic [2:0]  probe;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_c = '0; m_z = 0; m_n = 0; m_v = 0;
      end else begin
        foreach (q[i]) begin
          if (q[i].c_cyc == cyc && q[i].upd_c) m_c = q[i].y;
          if (q[i].c_cyc == cyc && q[i].upd_f) begin m_z = q[i].z; m_n = q[i].n; m_v = q[i].v; end
          if (q[i].done_cyc == cyc && q[i].we) m_regs[q[i].rd] = q[i].y;
        end
      end
      exp_ready = 1; exp_done = 0; probe = 3'(cyc);
      foreach (q[i]) begin
        if (cyc >= q[i].e0 && cyc < q[i].done_cyc) exp_ready = 0;
        if (cyc == q[i].done_cyc) begin exp_done = 1; probe = q[i].rd; end
      end
      dbg_rnum = probe;
      #1;
      check("m_ready",  32'(bus.cmd_ready), 32'(exp_ready));
      check("m_done",   32'(bus.done),      32'(exp_done));
      check("m_result", 32'(bus.result),    32'(m_c));
      check("m_Z",      32'(bus.Z),         32'(m_z));
      check("m_N",      32'(bus.N),         32'(m_n));
      check("m_V",      32'(bus.V),         32'(m_v));
      check("m_dbg",    32'(dbg_rdata),     32'(m_regs[probe]));
      while (q.size() > 0 && q[0].done_cyc <= cyc) void'(q.pop_front());
      if (rst_n && exp_ready && bus.cmd_valid)
        q.push_back(model(bus.cmd_op, bus.cmd_rd, m_regs[bus.cmd_rn], m_regs[bus.cmd_rm],
                          bus.cmd_shift, bus.cmd_imm, cyc + 1));
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at posedge+1; returns at accept edge +1 with last_e0 = accept edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [1:0] sh, input logic [15:0] imm,
                       input bit hold);
    logic r;
    r = 0;
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rn = rn; bus.cmd_rm = rm;
    bus.cmd_shift = sh; bus.cmd_imm = imm; bus.cmd_valid = 1;
    for (int i = 0; i < 20; i++) begin
      r = bus.cmd_ready;
      @(posedge clk); #1;
      if (r) break;
    end
    check("accept", 32'(r), 32'd1);
    last_e0 = cyc;
    if (!hold) bus.cmd_valid = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic issue8(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                        input logic [2:0] rm, input logic [7:0] imm);
    logic r;
    r = 0;
    bus8.cmd_op = op; bus8.cmd_rd = 2'(rd); bus8.cmd_rn = 2'(rn); bus8.cmd_rm = 2'(rm);
    bus8.cmd_shift = 2'b00; bus8.cmd_imm = imm; bus8.cmd_valid = 1;
    for (int i = 0; i < 20; i++) begin
      r = bus8.cmd_ready;
      @(posedge clk); #1;
      if (r) break;
    end
    check("accept8", 32'(r), 32'd1);
    bus8.cmd_valid = 0;
    r = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      r = bus8.done;
      if (r) break;
    end
    check("done8_seen", 32'(r), 32'd1);
  endtask

  initial begin : driver
    int lat;
    int e_and;
    bus.cmd_valid = 0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rn = '0; bus.cmd_rm = '0;
    bus.cmd_shift = '0; bus.cmd_imm = '0;
    bus8.cmd_valid = 0; bus8.cmd_op = '0; bus8.cmd_rd = '0; bus8.cmd_rn = '0; bus8.cmd_rm = '0;
    bus8.cmd_shift = '0; bus8.cmd_imm = '0;
    dbg8_rnum = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ready",  32'(bus.cmd_ready), 32'd1);
    check("rst_done",   32'(bus.done), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // MOVI R0,#7; MOVI R1,#2; ADD R2,R1,R0,LSL#1
    issue(3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 16'd7, 0); wait_done(lat);
    check("movi_lat", 32'(lat), 32'd1);
    check("movi_result", 32'(bus.result), 32'd7);
    issue(3'd0, 3'd1, 3'd0, 3'd0, 2'b00, 16'd2, 0); wait_done(lat);
    issue(3'd1, 3'd2, 3'd1, 3'd0, 2'b01, 16'd0, 0); wait_done(lat);
    check("add_lat", 32'(lat), 32'd4);
    check("add_result", 32'(bus.result), 32'd16);
    check("add_Z", 32'(bus.Z), 32'd0);

    // CMP R0,R0 then illegal op 111
    issue(3'd2, 3'd3, 3'd0, 3'd0, 2'b00, 16'd0, 0); wait_done(lat);
    check("cmp_result", 32'(bus.result), 32'd0);
    check("cmp_Z", 32'(bus.Z), 32'd1);
    issue(3'd7, 3'd0, 3'd0, 3'd0, 2'b00, 16'hFFFF, 0); wait_done(lat);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_result", 32'(bus.result), 32'd0);
    check("ill_Z", 32'(bus.Z), 32'd1);

    // 0x7FFF + 1 overflow
    issue(3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 16'h7FFF, 0); wait_done(lat);
    issue(3'd0, 3'd1, 3'd0, 3'd0, 2'b00, 16'h0001, 0); wait_done(lat);
    issue(3'd1, 3'd3, 3'd0, 3'd1, 2'b00, 16'd0, 0); wait_done(lat);
    check("ovf_result", 32'(bus.result), 32'h8000);
    check("ovf_Z", 32'(bus.Z), 32'd0);
    check("ovf_N", 32'(bus.N), 32'(NV_EN));
    check("ovf_V", 32'(bus.V), 32'(NV_EN));

    // Shifter variants on 0x8004
    issue(3'd0, 3'd4, 3'd0, 3'd0, 2'b00, 16'h8004, 0); wait_done(lat);
    issue(3'd5, 3'd5, 3'd0, 3'd4, 2'b11, 16'd0, 0); wait_done(lat);
    check("asr_result", 32'(bus.result), 32'hC002);
    issue(3'd5, 3'd6, 3'd0, 3'd4, 2'b10, 16'd0, 0); wait_done(lat);
    check("lsr_result", 32'(bus.result), 32'h4002);
    issue(3'd4, 3'd7, 3'd0, 3'd4, 2'b00, 16'd0, 0); wait_done(lat);
    check("mvn_result", 32'(bus.result), 32'h7FFB);

    // Valid held through busy with fields changing; second command accepted in the done cycle
    issue(3'd3, 3'd2, 3'd2, 3'd2, 2'b00, 16'd0, 1);
    e_and = last_e0;
    issue(3'd1, 3'd2, 3'd2, 3'd2, 2'b01, 16'd0, 0);
    check("b2b_gap", 32'(last_e0 - e_and), 32'd5);
    wait_done(lat);
    check("b2b_result", 32'(bus.result), 32'd48);

    // Reset while in EXEC
    issue(3'd1, 3'd3, 3'd0, 3'd1, 2'b00, 16'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_ready",  32'(bus.cmd_ready), 32'd1);
    check("mid_rst_done",   32'(bus.done), 32'd0);
    check("mid_rst_Z",      32'(bus.Z), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    issue(3'd0, 3'd1, 3'd0, 3'd0, 2'b00, 16'd5, 0); wait_done(lat);
    check("post_rst_result", 32'(bus.result), 32'd5);

    // 8-bit / 4-register instance: wrap-around and register-index wrap
    issue8(3'd0, 3'd0, 3'd0, 3'd0, 8'hFF);
    issue8(3'd0, 3'd1, 3'd0, 3'd0, 8'h01);
    issue8(3'd1, 3'd6, 3'd0, 3'd1, 8'h00);
    check("w8_result", 32'(bus8.result), 32'd0);
    check("w8_Z", 32'(bus8.Z), 32'd1);
    check("w8_N", 32'(bus8.N), 32'd0);
    check("w8_V", 32'(bus8.V), 32'd0);
    issue8(3'd0, 3'd5, 3'd0, 3'd0, 8'h33);
    dbg8_rnum = 2'd2; #1;
    check("w8_dbg_r2", 32'(dbg8_rdata), 32'd0);
    dbg8_rnum = 2'd1; #1;
    check("w8_dbg_r1", 32'(dbg8_rdata), 32'h33);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
